melody_sequencer: RTL and testbench

- Autoplay controller for the electronic-organ tone decoder: steps through a writable song memory and drives the decoder's IsPressed/data inputs with scale codes, notes, rests and articulation gaps.
- Also arbitrates between autoplay and the manual keypad. Manual keys have priority and pause playback.
- Sits between the keypad scanner/UI and the tone decoder. Outputs connect directly to the decoder's IsPressed and data.

---
 rtl/melody_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Autoplay sequencer for the organ tone decoder: plays a writable song memory and
// arbitrates with the manual keypad. Optional MELODY_TEMPO_ADJ_EN adds tempo_sel_i.
module melody_sequencer #(
    parameter int unsigned TICK_DIV = 6250000,
    parameter int unsigned GAP_CYC  = 1000000,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_en_i,
    input  logic              key_valid_i,
    input  logic [3:0]        key_data_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
`ifdef MELODY_TEMPO_ADJ_EN
    input  logic [1:0]        tempo_sel_i,
`endif
    output logic              tone_pressed_o,
    output logic [3:0]        tone_data_o,
    output logic              playing_o,
    output logic [ADDR_W-1:0] note_idx_o
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam int unsigned TICK_LONG = 2 * TICK_DIV;
    localparam int unsigned CNT_MAX   = (TICK_LONG > GAP_CYC) ? TICK_LONG : GAP_CYC;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned GAP_LAST  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam bit          HAS_GAP   = (GAP_CYC != 0);
`ifdef MELODY_TEMPO_ADJ_EN
    localparam int unsigned TICK_HALF = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
    localparam int unsigned TICK_QTR  = (TICK_DIV / 4 > 0) ? TICK_DIV / 4 : 1;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCALE  = 3'd1,
        NOTE   = 3'd2,
        GAP    = 3'd3,
        END_ST = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    tick_len_q, tick_len_d;
    logic [CNT_W-1:0]    tick_len_sel_c;
    logic [2:0]          tick_q, tick_d;
    logic [7:0]          entry_q, entry_d;
    logic                playing_q, playing_d;
    logic                pressed_q, pressed_d;
    logic [3:0]          data_q, data_d;
    logic                key_q;
    logic                adv_c, load_c;
    logic [7:0]          fetch_c;

    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH-1:0]    vld_q;

    // Built-in tune for entries never written: ascending mid-octave scale, then END.
    function automatic logic [7:0] default_entry(input logic [ADDR_W-1:0] idx);
        logic [31:0] i;
        i = 32'(idx);
        if (i < 32'd7) return {2'b01, 3'(i + 32'd1), 3'd1};
        return 8'hC0;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n)   vld_q <= '0;
        else if (wr_en_i) vld_q[wr_addr_i] <= 1'b1;
    end

`ifdef MELODY_TEMPO_ADJ_EN
    always_comb begin
        case (tempo_sel_i)
            2'b01:   tick_len_sel_c = CNT_W'(TICK_LONG);
            2'b10:   tick_len_sel_c = CNT_W'(TICK_HALF);
            2'b11:   tick_len_sel_c = CNT_W'(TICK_QTR);
            default: tick_len_sel_c = CNT_W'(TICK_DIV);
        endcase
    end
`else
    assign tick_len_sel_c = CNT_W'(TICK_DIV);
`endif

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            tick_len_q <= CNT_W'(TICK_DIV);
            tick_q     <= '0;
            entry_q    <= '0;
            playing_q  <= 1'b0;
            pressed_q  <= 1'b0;
            data_q     <= '0;
            key_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tick_len_q <= tick_len_d;
            tick_q     <= tick_d;
            entry_q    <= entry_d;
            playing_q  <= playing_d;
            pressed_q  <= pressed_d;
            data_q     <= data_d;
            key_q      <= key_valid_i;
        end
    end

    // Next state; outputs are derived from the next state so they register in step.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        tick_len_d = tick_len_q;
        tick_d     = tick_q;
        entry_d    = entry_q;
        playing_d  = playing_q;
        pressed_d  = 1'b0;
        data_d     = 4'h0;
        adv_c      = 1'b0;
        load_c     = 1'b0;
        fetch_c    = 8'h00;

        if (stop_i) begin
            state_d   = IDLE;
            idx_d     = '0;
            cnt_d     = '0;
            tick_d    = '0;
            playing_d = 1'b0;
        end else if (start_i) begin
            state_d   = SCALE;
            idx_d     = '0;
            playing_d = 1'b1;
            load_c    = 1'b1;
        end else if (key_valid_i) begin
            state_d = state_q;
        end else if (key_q && (state_q == SCALE || state_q == NOTE || state_q == GAP)) begin
            // Keypad may have changed the decoder scale: replay the entry from SCALE.
            state_d = SCALE;
            load_c  = 1'b1;
        end else begin
            case (state_q)
                SCALE: begin
                    if (entry_q[7:6] == 2'b11) begin
                        state_d = END_ST;
                    end else begin
                        state_d    = NOTE;
                        cnt_d      = '0;
                        tick_d     = '0;
                        tick_len_d = tick_len_sel_c;
                    end
                end
                NOTE: begin
                    if (cnt_q == tick_len_q - CNT_W'(1)) begin
                        cnt_d = '0;
                        if (tick_q == entry_q[2:0]) begin
                            if (HAS_GAP) state_d = GAP;
                            else         adv_c   = 1'b1;
                        end else begin
                            tick_d = tick_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_W'(GAP_LAST)) begin
                        cnt_d = '0;
                        adv_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                END_ST: begin
                    idx_d = '0;
                    if (loop_en_i) begin
                        state_d = SCALE;
                        load_c  = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        playing_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Last entry wraps to 0 and is handled as END.
        if (adv_c) begin
            if (idx_q == ADDR_W'(DEPTH - 1)) begin
                state_d = END_ST;
                idx_d   = '0;
            end else begin
                state_d = SCALE;
                idx_d   = idx_q + ADDR_W'(1);
                load_c  = 1'b1;
            end
        end

        if (load_c) begin
            fetch_c = vld_q[idx_d] ? mem_q[idx_d] : default_entry(idx_d);
            entry_d = fetch_c;
            cnt_d   = '0;
            tick_d  = '0;
        end

        if (key_valid_i) begin
            pressed_d = (key_data_i != 4'h0) && (key_data_i <= 4'h7);
            data_d    = key_data_i;
        end else begin
            case (state_d)
                SCALE: data_d = 4'hA + {2'b00, entry_d[7:6]};
                NOTE: begin
                    if (entry_d[5:3] != 3'd0) begin
                        pressed_d = 1'b1;
                        data_d    = {1'b0, entry_d[5:3]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign tone_pressed_o = pressed_q;
    assign tone_data_o    = data_q;
    assign playing_o      = playing_q;
    assign note_idx_o     = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_DIV=10, GAP_CYC=2, ADDR_W=3.
module tb_melody_sequencer;

    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned GAP_CYC  = 2;
    localparam int unsigned ADDR_W   = 3;

    logic              clk = 1'b0;
    logic              sys_rst_n;
    logic              start, stop, loop_en, key_valid, wr_en;
    logic [3:0]        key_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              tone_pressed, playing;
    logic [3:0]        tone_data;
    logic [ADDR_W-1:0] note_idx;
`ifdef MELODY_TEMPO_ADJ_EN
    logic [1:0]        tempo_sel = 2'b00;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    melody_sequencer #(.TICK_DIV(TICK_DIV), .GAP_CYC(GAP_CYC), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .sys_rst_n      (sys_rst_n),
        .start_i        (start),
        .stop_i         (stop),
        .loop_en_i      (loop_en),
        .key_valid_i    (key_valid),
        .key_data_i     (key_data),
        .wr_en_i        (wr_en),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
`ifdef MELODY_TEMPO_ADJ_EN
        .tempo_sel_i    (tempo_sel),
`endif
        .tone_pressed_o (tone_pressed),
        .tone_data_o    (tone_data),
        .playing_o      (playing),
        .note_idx_o     (note_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Leaves the bench in cycle 1 (first SCALE cycle).
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    task automatic write_basic_song();
        write_entry(3'd0, 8'b01_011_001);
        write_entry(3'd1, 8'b11_000_000);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        step(); step();
        total++;
        if ({tone_pressed, tone_data, playing, note_idx} !== 9'd0) begin
            bad++; $display("FAIL reset_state: got p=%b d=%h pl=%b i=%0d want all 0",
                            tone_pressed, tone_data, playing, note_idx);
        end
        sys_rst_n = 1'b1;
        step();
        // Default tune entry 0 is mid octave, note 1.
        pulse_start();
        total++;
        if (tone_data !== 4'hB || tone_pressed !== 1'b0 || playing !== 1'b1) begin
            bad++; $display("FAIL default_scale: got d=%h p=%b pl=%b want B/0/1", tone_data, tone_pressed, playing);
        end
        step();
        total++;
        if (tone_data !== 4'h1 || tone_pressed !== 1'b1) begin
            bad++; $display("FAIL default_note: got d=%h p=%b want 1/1", tone_data, tone_pressed);
        end
        do_stop();
    endtask

    task automatic test_basic();
        write_basic_song();
        loop_en = 1'b0;
        pulse_start();
        total++;
        if (tone_data !== 4'hB || tone_pressed !== 1'b0 || note_idx !== 3'd0 || playing !== 1'b1) begin
            bad++; $display("FAIL basic_scale: got d=%h p=%b i=%0d pl=%b want B/0/0/1", tone_data, tone_pressed, note_idx, playing);
        end
        for (int c = 2; c <= 21; c++) begin
            step();
            total++;
            if (tone_data !== 4'h3 || tone_pressed !== 1'b1) begin
                bad++; $display("FAIL basic_note c%0d: got d=%h p=%b want 3/1", c, tone_data, tone_pressed);
            end
        end
        for (int c = 22; c <= 23; c++) begin
            step();
            total++;
            if (tone_data !== 4'h0 || tone_pressed !== 1'b0) begin
                bad++; $display("FAIL basic_gap c%0d: got d=%h p=%b want 0/0", c, tone_data, tone_pressed);
            end
        end
        step();
        total++;
        if (tone_data !== 4'hD || note_idx !== 3'd1) begin
            bad++; $display("FAIL basic_end_scale: got d=%h i=%0d want D/1", tone_data, note_idx);
        end
        step();
        total++;
        if (playing !== 1'b1 || tone_data !== 4'h0) begin
            bad++; $display("FAIL basic_end_st: got pl=%b d=%h want 1/0", playing, tone_data);
        end
        step();
        total++;
        if (playing !== 1'b0 || note_idx !== 3'd0) begin
            bad++; $display("FAIL basic_idle: got pl=%b i=%0d want 0/0", playing, note_idx);
        end
    endtask

    task automatic test_rest();
        write_entry(3'd0, 8'b00_000_000);
        write_entry(3'd1, 8'b11_000_000);
        pulse_start();
        total++;
        if (tone_data !== 4'hA || tone_pressed !== 1'b0) begin
            bad++; $display("FAIL rest_scale: got d=%h p=%b want A/0", tone_data, tone_pressed);
        end
        for (int c = 2; c <= 13; c++) begin
            step();
            total++;
            if (tone_data !== 4'h0 || tone_pressed !== 1'b0 || playing !== 1'b1) begin
                bad++; $display("FAIL rest_silent c%0d: got d=%h p=%b pl=%b want 0/0/1", c, tone_data, tone_pressed, playing);
            end
        end
        step();
        total++;
        if (tone_data !== 4'hD) begin
            bad++; $display("FAIL rest_next_scale: got d=%h want D", tone_data);
        end
        step(); step();
        total++;
        if (playing !== 1'b0) begin
            bad++; $display("FAIL rest_idle: got pl=%b want 0", playing);
        end
    endtask

    task automatic test_loop();
        write_basic_song();
        loop_en = 1'b1;
        pulse_start();
        for (int c = 2; c <= 25; c++) step();
        total++;
        if (playing !== 1'b1) begin
            bad++; $display("FAIL loop_end_st: got pl=%b want 1", playing);
        end
        step();
        total++;
        if (tone_data !== 4'hB || note_idx !== 3'd0 || playing !== 1'b1) begin
            bad++; $display("FAIL loop_rescale: got d=%h i=%0d pl=%b want B/0/1", tone_data, note_idx, playing);
        end
        step();
        total++;
        if (tone_data !== 4'h3 || tone_pressed !== 1'b1) begin
            bad++; $display("FAIL loop_note: got d=%h p=%b want 3/1", tone_data, tone_pressed);
        end
        loop_en = 1'b0;
        do_stop();
    endtask

    task automatic test_manual();
        write_basic_song();
        pulse_start();
        for (int c = 2; c <= 5; c++) step();
        key_valid = 1'b1; key_data = 4'h5;
        for (int c = 6; c <= 12; c++) begin
            step();
            total++;
            if (tone_data !== 4'h5 || tone_pressed !== 1'b1 || playing !== 1'b1) begin
                bad++; $display("FAIL manual_hold c%0d: got d=%h p=%b pl=%b want 5/1/1", c, tone_data, tone_pressed, playing);
            end
        end
        key_valid = 1'b0;
        step();
        total++;
        if (tone_data !== 4'hB || tone_pressed !== 1'b0 || note_idx !== 3'd0) begin
            bad++; $display("FAIL manual_rescale: got d=%h p=%b i=%0d want B/0/0", tone_data, tone_pressed, note_idx);
        end
        for (int c = 14; c <= 33; c++) begin
            step();
            total++;
            if (tone_data !== 4'h3 || tone_pressed !== 1'b1) begin
                bad++; $display("FAIL manual_replay c%0d: got d=%h p=%b want 3/1", c, tone_data, tone_pressed);
            end
        end
        step();
        total++;
        if (tone_data !== 4'h0 || tone_pressed !== 1'b0) begin
            bad++; $display("FAIL manual_gap: got d=%h p=%b want 0/0", tone_data, tone_pressed);
        end
        do_stop();
        // Pass-through while idle: scale codes never press.
        key_valid = 1'b1; key_data = 4'hC;
        step();
        total++;
        if (tone_data !== 4'hC || tone_pressed !== 1'b0 || playing !== 1'b0) begin
            bad++; $display("FAIL idle_key_scale: got d=%h p=%b pl=%b want C/0/0", tone_data, tone_pressed, playing);
        end
        key_data = 4'h7;
        step();
        total++;
        if (tone_data !== 4'h7 || tone_pressed !== 1'b1) begin
            bad++; $display("FAIL idle_key_note: got d=%h p=%b want 7/1", tone_data, tone_pressed);
        end
        // Start while key held: playing rises, SCALE waits for release.
        key_data = 4'h2;
        pulse_start();
        total++;
        if (playing !== 1'b1 || tone_data !== 4'h2 || tone_pressed !== 1'b1) begin
            bad++; $display("FAIL start_key_hold: got pl=%b d=%h p=%b want 1/2/1", playing, tone_data, tone_pressed);
        end
        key_valid = 1'b0;
        step();
        total++;
        if (tone_data !== 4'hB || tone_pressed !== 1'b0) begin
            bad++; $display("FAIL start_key_release: got d=%h p=%b want B/0", tone_data, tone_pressed);
        end
        step();
        total++;
        if (tone_data !== 4'h3 || tone_pressed !== 1'b1) begin
            bad++; $display("FAIL start_key_note: got d=%h p=%b want 3/1", tone_data, tone_pressed);
        end
        do_stop();
    endtask

    task automatic test_start_stop();
        write_entry(3'd0, 8'b01_001_000);
        write_entry(3'd1, 8'b10_010_000);
        write_entry(3'd2, 8'b11_000_000);
        pulse_start();
        for (int c = 2; c <= 16; c++) step();
        // Restart while playing entry 1.
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (tone_data !== 4'hB || note_idx !== 3'd0 || playing !== 1'b1) begin
            bad++; $display("FAIL restart: got d=%h i=%0d pl=%b want B/0/1", tone_data, note_idx, playing);
        end
        for (int c = 2; c <= 18; c++) step();
        total++;
        if (note_idx !== 3'd1 || tone_data !== 4'h2 || tone_pressed !== 1'b1) begin
            bad++; $display("FAIL second_note: got i=%0d d=%h p=%b want 1/2/1", note_idx, tone_data, tone_pressed);
        end
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        total++;
        if ({tone_pressed, tone_data, playing, note_idx} !== 9'd0) begin
            bad++; $display("FAIL start_stop: got p=%b d=%h pl=%b i=%0d want all 0", tone_pressed, tone_data, playing, note_idx);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 8; k++) write_entry(3'(k), {2'b01, 3'(k % 7 + 1), 3'b000});
        for (int lp = 0; lp < 2; lp++) begin
            loop_en = (lp == 1);
            pulse_start();
            for (int c = 2; c <= 92; c++) step();
            total++;
            if (note_idx !== 3'd7 || tone_data !== 4'hB) begin
                bad++; $display("FAIL wrap_last_scale lp%0d: got i=%0d d=%h want 7/B", lp, note_idx, tone_data);
            end
            step();
            total++;
            if (tone_data !== 4'h1 || tone_pressed !== 1'b1) begin
                bad++; $display("FAIL wrap_last_note lp%0d: got d=%h p=%b want 1/1", lp, tone_data, tone_pressed);
            end
            for (int c = 94; c <= 105; c++) step();
            total++;
            if (note_idx !== 3'd0 || playing !== 1'b1 || tone_data !== 4'h0) begin
                bad++; $display("FAIL wrap_end lp%0d: got i=%0d pl=%b d=%h want 0/1/0", lp, note_idx, playing, tone_data);
            end
            step();
            total++;
            if (lp == 0 && playing !== 1'b0) begin
                bad++; $display("FAIL wrap_stop: got pl=%b want 0", playing);
            end else if (lp == 1 && (playing !== 1'b1 || tone_data !== 4'hB || note_idx !== 3'd0)) begin
                bad++; $display("FAIL wrap_loop: got pl=%b d=%h i=%0d want 1/B/0", playing, tone_data, note_idx);
            end
        end
        loop_en = 1'b0;
        do_stop();
    endtask

    task automatic test_async_reset();
        write_basic_song();
        pulse_start();
        step(); step();
        #2 sys_rst_n = 1'b0;
        #1;
        total++;
        if ({tone_pressed, tone_data, playing, note_idx} !== 9'd0) begin
            bad++; $display("FAIL async_reset: got p=%b d=%h pl=%b i=%0d want all 0", tone_pressed, tone_data, playing, note_idx);
        end
        step();
        sys_rst_n = 1'b1;
        step();
        total++;
        if (playing !== 1'b0 || tone_pressed !== 1'b0) begin
            bad++; $display("FAIL after_reset: got pl=%b p=%b want 0/0", playing, tone_pressed);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        key_valid = 1'b0; key_data = 4'h0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_basic();
        test_rest();
        test_loop();
        test_manual();
        test_start_stop();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
